mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the CPU instruction-fetch port and data port.

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/mem_arbiter_rr_arb2.sv | 31 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way combinational round-robin arbiter between the fetch and data ports.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic req_if,
    input  logic req_d,
    input  logic last_owner,
    input  logic enable,
    output logic gnt_if,
    output logic gnt_d
);

    // On a tie the port that did not win last time is granted.
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (enable) begin
            if (req_if && req_d) begin
                if (last_owner == OWN_D) begin
                    gnt_if = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_if = req_if;
                gnt_d  = req_d;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported fixed-latency memory between the CPU fetch and data ports.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             last_owner;
    logic             arb_en;
    logic             arb_req_if;
    logic             arb_req_d;
    logic             gnt_if;
    logic             gnt_d;
    logic             grant;

    // Arbitrate only in IDLE and DONE; in DONE the just-served port still shows its old request.
    always_comb begin
        arb_en     = 1'b0;
        arb_req_if = if_req;
        arb_req_d  = d_req;
        case (state)
            ST_IDLE: arb_en = 1'b1;
            ST_DONE: begin
                arb_en = 1'b1;
                if (last_owner == OWN_IF) begin
                    arb_req_if = 1'b0;
                end else begin
                    arb_req_d = 1'b0;
                end
            end
            default: arb_en = 1'b0;
        endcase
    end

    rr_arb2 u_rr_arb2 (
        .req_if     (arb_req_if),
        .req_d      (arb_req_d),
        .last_owner (last_owner),
        .enable     (arb_en),
        .gnt_if     (gnt_if),
        .gnt_d      (gnt_d)
    );

    assign grant = gnt_if | gnt_d;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (grant) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  if (cnt == '0) next_state = ST_DONE;
            ST_DONE:  next_state = grant ? ST_ISSUE : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are decoded from next_state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
            last_owner <= OWN_IF;
            cnt        <= '0;
        end else begin
            mem_en   <= (next_state == ST_ISSUE);
            busy     <= (next_state != ST_IDLE);
            if_ready <= (next_state == ST_DONE) && (last_owner == OWN_IF);
            d_ready  <= (next_state == ST_DONE) && (last_owner == OWN_D);

            if (gnt_d) begin
                last_owner <= OWN_D;
                mem_addr   <= d_addr;
                mem_we     <= d_we;
                mem_wdata  <= d_wdata;
            end else if (gnt_if) begin
                last_owner <= OWN_IF;
                mem_addr   <= if_addr;
                mem_we     <= 1'b0;
            end

            if (state == ST_ISSUE) begin
                cnt <= CNT_W'(MEM_LAT - 1);
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            // mem_rdata is only valid in the final WAIT cycle.
            if (state == ST_WAIT && cnt == '0) begin
                if (last_owner == OWN_D) begin
                    d_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=4.
module tb_mem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          drive;
        int          en;
        bit          granted;
    } acc_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h3C01_0040;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp, input int lat);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lat=%0d cycle=%0d got=0x%08h expected=0x%08h", name, lat, cyc, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int LAT = (g == 0) ? 1 : 4;

        logic        rst;
        logic        if_req, d_req, d_we;
        logic [31:0] if_addr, d_addr, d_wdata;
        logic [31:0] if_rdata, d_rdata;
        logic        if_ready, d_ready;
        logic        mem_en, mem_we, busy;
        logic [31:0] mem_addr, mem_wdata;
        logic [31:0] mem_rdata = 32'h0;

        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .reset     (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_rdata  (if_rdata),
            .if_ready  (if_ready),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_rdata   (d_rdata),
            .d_ready   (d_ready),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata),
            .busy      (busy)
        );

        // Memory: read data valid only LAT cycles after the strobe, noise otherwise.
        logic [31:0] env_mem [logic [31:0]];
        logic [31:0] pend_data = 32'h0;
        int          pend_cyc = -1;

        always @(negedge clk) begin
            mem_rdata = (pend_cyc == cyc) ? pend_data : $urandom;
            if (!rst && mem_en) begin
                if (mem_we) begin
                    env_mem[mem_addr] = mem_wdata;
                end else begin
                    pend_data = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
                    pend_cyc  = cyc + LAT;
                end
            end
        end

        // Reference state: outstanding request per port, reference memory, arbitration history.
        acc_t        q [2][$];
        logic [31:0] ref_mem [logic [31:0]];
        int          model_last = 0;
        int          last_ready = -100;
        bit          prev_en = 1'b0;
        bit          gnt_seen [2];
        bit          elig [2];
        bit          inflight;
        int          own;
        int          exp_c;
        acc_t        e;

        always @(negedge clk) begin
            if (rst) begin
                prev_en = 1'b0;
            end else begin
                if (mem_en) begin
                    chk("mem_en_back_to_back", 32'(prev_en), 32'd0, LAT);
                    for (int p = 0; p < 2; p++) begin
                        elig[p] = 1'b0;
                        if (q[p].size() > 0) elig[p] = !q[p][0].granted && (q[p][0].drive < cyc);
                    end
                    if (!elig[0] && !elig[1]) begin
                        chk("spurious_mem_en", 32'd1, 32'd0, LAT);
                    end else begin
                        if (elig[0] && elig[1]) own = (model_last == 0) ? 1 : 0;
                        else own = elig[1] ? 1 : 0;
                        e = q[own][0];
                        chk(own ? "grant_addr_d" : "grant_addr_if", mem_addr, e.addr, LAT);
                        chk("grant_we", 32'(mem_we), 32'(e.we), LAT);
                        if (e.we) chk("grant_wdata", mem_wdata, e.wdata, LAT);
                        exp_c = e.drive + 1;
                        if (last_ready + 1 > exp_c) exp_c = last_ready + 1;
                        chk("issue_cycle", 32'(cyc), 32'(exp_c), LAT);
                        q[own][0].granted = 1'b1;
                        q[own][0].en      = cyc;
                        model_last        = own;
                        gnt_seen[own]     = 1'b1;
                    end
                end
                prev_en = mem_en;

                inflight = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (q[p].size() > 0) begin
                        if (q[p][0].granted) inflight = 1'b1;
                    end
                end
                chk("busy", 32'(busy), 32'(inflight), LAT);

                for (int p = 0; p < 2; p++) begin
                    if ((p == 0) ? if_ready : d_ready) begin
                        if (q[p].size() == 0) begin
                            chk(p ? "spurious_d_ready" : "spurious_if_ready", 32'd1, 32'd0, LAT);
                        end else if (!q[p][0].granted) begin
                            chk(p ? "spurious_d_ready" : "spurious_if_ready", 32'd1, 32'd0, LAT);
                        end else begin
                            e = q[p].pop_front();
                            chk("ready_latency", 32'(cyc - e.en), 32'(LAT + 1), LAT);
                            if (!e.we) chk(p ? "d_rdata" : "if_rdata", (p == 0) ? if_rdata : d_rdata, e.exp, LAT);
                            last_ready = cyc;
                        end
                    end
                end
            end
        end

        task automatic flush_model();
            q[0].delete();
            q[1].delete();
            model_last  = 0;
            last_ready  = -100;
            prev_en     = 1'b0;
            gnt_seen[0] = 1'b0;
            gnt_seen[1] = 1'b0;
        endtask

        task automatic drive_req(input int p, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
            acc_t n;
            n.we      = (p == 1) ? we : 1'b0;
            n.addr    = addr;
            n.wdata   = wdata;
            n.exp     = ref_mem.exists(addr) ? ref_mem[addr] : init_val(addr);
            n.drive   = cyc;
            n.en      = 0;
            n.granted = 1'b0;
            if (n.we) ref_mem[addr] = wdata;
            q[p].push_back(n);
            gnt_seen[p] = 1'b0;
            if (p == 0) begin
                if_req = 1'b1; if_addr = addr;
            end else begin
                d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
            end
        endtask

        task automatic release_req(input int p);
            if (p == 0) if_req = 1'b0;
            else d_req = 1'b0;
        endtask

        // One CPU-side access; returns at the edge after ready, request still held.
        task automatic do_req(input int p, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int gap, input bit drop);
            bit seen;
            if (gap > 0) begin
                release_req(p);
                repeat (gap) begin @(posedge clk); #1; end
            end
            drive_req(p, we, addr, wdata);
            if (drop) begin
                for (int i = 0; i < 100 && !gnt_seen[p]; i++) @(negedge clk);
                @(posedge clk); #1;
                release_req(p);
            end
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                seen = (p == 0) ? if_ready : d_ready;
            end
            if (!seen) begin
                chk(p ? "d_ready_timeout" : "if_ready_timeout", 32'd0, 32'd1, LAT);
                q[p].delete();
            end
            @(posedge clk); #1;
        endtask

        task automatic do_reset();
            rst = 1'b1;
            if_req = 1'b0;
            d_req = 1'b0;
            flush_model();
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst = 1'b0;
        endtask

        initial begin : orch
            rst = 1'b1;
            if_req = 1'b0; if_addr = 32'h0;
            d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
            repeat (2) @(posedge clk);
            #1;
            chk("reset_busy", 32'(busy), 32'd0, LAT);
            chk("reset_mem_en", 32'(mem_en), 32'd0, LAT);
            chk("reset_if_ready", 32'(if_ready), 32'd0, LAT);
            chk("reset_d_ready", 32'(d_ready), 32'd0, LAT);
            chk("reset_mem_addr", mem_addr, 32'd0, LAT);
            rst = 1'b0;

            // Fetch only, then store and read back.
            do_req(0, 1'b0, 32'h0040_0000, 32'h0, 0, 1'b0);
            release_req(0);
            do_req(1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1, 1'b0);
            do_req(1, 1'b0, 32'h1001_0004, 32'h0, 1, 1'b0);
            release_req(1);

            // Both ports held from reset: D first, then strict alternation.
            do_reset();
            fork
                begin
                    for (int i = 0; i < 4; i++)
                        do_req(0, 1'b0, 32'h0040_0000 + 32'(i * 4), 32'h0, 0, 1'b0);
                    release_req(0);
                end
                begin
                    for (int i = 0; i < 4; i++)
                        do_req(1, 1'b0, 32'h1001_0000 + 32'(i * 4), 32'h0, 0, 1'b0);
                    release_req(1);
                end
            join

            // Random traffic on both ports, with requests sometimes dropped mid-access.
            fork
                begin
                    for (int i = 0; i < 30; i++)
                        do_req(0, 1'b0, 32'h0040_0000 + ($urandom_range(0, 63) << 2), 32'h0,
                               int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
                    release_req(0);
                end
                begin
                    for (int i = 0; i < 30; i++)
                        do_req(1, 1'($urandom_range(0, 1)), 32'h1001_0000 + ($urandom_range(0, 15) << 2),
                               $urandom, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
                    release_req(1);
                end
            join
            repeat (3) @(posedge clk);
            #1;

            // Reset during WAIT abandons the access without a ready pulse.
            drive_req(1, 1'b0, 32'h1001_0004, 32'h0);
            for (int i = 0; i < 100 && !gnt_seen[1]; i++) @(negedge clk);
            @(posedge clk); #1;
            if (LAT > 1) begin @(posedge clk); #1; end
            rst = 1'b1;
            #1;
            chk("midreset_busy", 32'(busy), 32'd0, LAT);
            chk("midreset_d_ready", 32'(d_ready), 32'd0, LAT);
            chk("midreset_mem_en", 32'(mem_en), 32'd0, LAT);
            d_req = 1'b0;
            flush_model();
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (LAT + 6) @(posedge clk);
            #1;
            do_req(1, 1'b0, 32'h1001_0004, 32'h0, 0, 1'b0);
            release_req(1);
            repeat (2) @(posedge clk);
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 40000 && !(done[0] && done[1]); i++) @(posedge clk);
        if (!(done[0] && done[1])) begin
            n_checks++;
            n_fail++;
            $display("FAIL global_timeout got=not_done expected=done");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
